// File: rtl/scan_sel_sequencer_pkg.sv
// Shared constants and state encoding for the scan select sequencer.
// NUM_CH is fixed at 8 so sel maps directly onto a 3-to-8 decoder input.
package scan_seq_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/scan_sel_sequencer_next_ch_finder.sv
// Combinational wrap-around priority search over the channel mask.
// Given the current index, finds the next enabled channel in the scan
// direction, flags whether that step wrapped, and reports the first channel
// a fresh sweep would start from. With an empty mask the outputs are
// don't-care; the sequencer never enters a sweep with an empty mask.
module next_ch_finder
  import scan_seq_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur_idx,
  input  logic              dir,
  output logic [SEL_W-1:0]  next_idx,
  output logic              wrap,
  output logic [SEL_W-1:0]  first_idx
);

  logic             found_next;
  logic             found_first;
  logic [SEL_W-1:0] step;
  logic [SEL_W-1:0] cand;
  logic [SEL_W-1:0] first_cand;

  // Search up to NUM_CH steps away (the last step lands back on cur_idx, which
  // covers the single-enabled-channel case) and pick the first enabled hit.
  always_comb begin
    next_idx    = cur_idx;
    found_next  = 1'b0;
    first_idx   = '0;
    found_first = 1'b0;
    step        = '0;
    cand        = '0;
    first_cand  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      step = SEL_W'(i);
      cand = dir ? (cur_idx - step) : (cur_idx + step);
      if (!found_next && mask[cand]) begin
        next_idx   = cand;
        found_next = 1'b1;
      end
    end
    wrap = dir ? (next_idx >= cur_idx) : (next_idx <= cur_idx);
    for (int j = 0; j < NUM_CH; j++) begin
      first_cand = dir ? SEL_W'(NUM_CH - 1 - j) : SEL_W'(j);
      if (!found_first && mask[first_cand]) begin
        first_idx   = first_cand;
        found_first = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scan_sel_sequencer.sv
// Scan select sequencer: steps a 3-bit decoder select through the enabled
// channels of a latched mask, holding each for max(dwell,1) cycles, in
// single-shot or continuous mode. All outputs are registered.
// Optional macro SCAN_DIR_EN adds a 'dir' input (latched at start) that
// selects a descending scan when 1; without it the scan is ascending only.
module scan_sel_sequencer
  import scan_seq_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode_cont,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_DIR_EN
  input  logic               dir,
`endif
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               busy,
  output logic               sweep_done,
  output logic               err_no_ch
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               sel_valid_q, sel_valid_d;
  logic               busy_q, busy_d;
  logic               sweep_done_q, sweep_done_d;
  logic               err_no_ch_q, err_no_ch_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic               mode_q, mode_d;
  logic               dir_q, dir_d;

  logic               dir_in;
  logic [DWELL_W-1:0] dwell_eff;
  logic [NUM_CH-1:0]  find_mask;
  logic               find_dir;
  logic [SEL_W-1:0]   next_idx;
  logic               wrap;
  logic [SEL_W-1:0]   first_idx;

`ifdef SCAN_DIR_EN
  assign dir_in = dir;
`else
  assign dir_in = 1'b0;
`endif

  // A zero dwell behaves as a one-cycle hold, so the counter never underflows.
  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

  // In IDLE the finder looks at the live inputs to pick the first channel;
  // during a sweep it only ever sees the values latched at start.
  assign find_mask = (state_q == IDLE) ? ch_mask : mask_q;
  assign find_dir  = (state_q == IDLE) ? dir_in  : dir_q;

  next_ch_finder u_finder (
    .mask      (find_mask),
    .cur_idx   (sel_q),
    .dir       (find_dir),
    .next_idx  (next_idx),
    .wrap      (wrap),
    .first_idx (first_idx)
  );

  // Next-state and registered-output logic; stop outranks a hold expiry.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    sel_valid_d  = sel_valid_q;
    busy_d       = busy_q;
    sweep_done_d = 1'b0;
    err_no_ch_d  = 1'b0;
    cnt_d        = cnt_q;
    dwell_d      = dwell_q;
    mask_d       = mask_q;
    mode_d       = mode_q;
    dir_d        = dir_q;
    case (state_q)
      IDLE: begin
        sel_d       = '0;
        sel_valid_d = 1'b0;
        busy_d      = 1'b0;
        if (start) begin
          if (ch_mask != '0) begin
            state_d     = ACTIVE;
            mask_d      = ch_mask;
            dwell_d     = dwell_eff;
            mode_d      = mode_cont;
            dir_d       = dir_in;
            sel_d       = first_idx;
            cnt_d       = dwell_eff;
            sel_valid_d = 1'b1;
            busy_d      = 1'b1;
          end else begin
            err_no_ch_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (stop) begin
          state_d     = IDLE;
          sel_d       = '0;
          sel_valid_d = 1'b0;
          busy_d      = 1'b0;
        end else if (cnt_q <= DWELL_W'(1)) begin
          cnt_d = dwell_q;
          if (wrap) begin
            sweep_done_d = 1'b1;
            if (mode_q) begin
              sel_d = next_idx;
            end else begin
              state_d     = IDLE;
              sel_d       = '0;
              sel_valid_d = 1'b0;
              busy_d      = 1'b0;
            end
          end else begin
            sel_d = next_idx;
          end
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        sel_d       = '0;
        sel_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State, outputs and latched configuration, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      sel_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
      err_no_ch_q  <= 1'b0;
      cnt_q        <= '0;
      dwell_q      <= '0;
      mask_q       <= '0;
      mode_q       <= 1'b0;
      dir_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      sel_valid_q  <= sel_valid_d;
      busy_q       <= busy_d;
      sweep_done_q <= sweep_done_d;
      err_no_ch_q  <= err_no_ch_d;
      cnt_q        <= cnt_d;
      dwell_q      <= dwell_d;
      mask_q       <= mask_d;
      mode_q       <= mode_d;
      dir_q        <= dir_d;
    end
  end

  assign sel        = sel_q;
  assign sel_valid  = sel_valid_q;
  assign busy       = busy_q;
  assign sweep_done = sweep_done_q;
  assign err_no_ch  = err_no_ch_q;

endmodule

// File: tb/tb_scan_sel_sequencer.sv
// Directed testbench for scan_sel_sequencer (ascending build; when
// SCAN_DIR_EN is defined the dir input is tied to 0).
module tb_scan_sel_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       mode_cont;
  logic [7:0] ch_mask;
  logic [7:0] dwell;
`ifdef SCAN_DIR_EN
  logic       dir;
`endif
  logic [2:0] sel;
  logic       sel_valid;
  logic       busy;
  logic       sweep_done;
  logic       err_no_ch;

  int checks;
  int errors;

  scan_sel_sequencer #(.DWELL_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .mode_cont  (mode_cont),
    .ch_mask    (ch_mask),
    .dwell      (dwell),
`ifdef SCAN_DIR_EN
    .dir        (dir),
`endif
    .sel        (sel),
    .sel_valid  (sel_valid),
    .busy       (busy),
    .sweep_done (sweep_done),
    .err_no_ch  (err_no_ch)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s_start, input logic s_stop,
                               input logic s_mode, input logic [7:0] s_mask,
                               input logic [7:0] s_dwell);
    start     = s_start;
    stop      = s_stop;
    mode_cont = s_mode;
    ch_mask   = s_mask;
    dwell     = s_dwell;
  endtask

  // Compares {sel, sel_valid, busy, sweep_done, err_no_ch} as one vector.
  task automatic checkOutput(input string tag, input logic [2:0] e_sel,
                             input logic e_valid, input logic e_busy,
                             input logic e_done, input logic e_err);
    logic [6:0] obs;
    logic [6:0] exp;
    obs = {sel, sel_valid, busy, sweep_done, err_no_ch};
    exp = {e_sel, e_valid, e_busy, e_done, e_err};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed sel/valid/busy/done/err=%b expected %b",
             tag, obs, exp);
    end
  endtask

  initial begin
    logic [2:0] seq3 [9];
    logic [2:0] exp_sel;
    checks = 0;
    errors = 0;
`ifdef SCAN_DIR_EN
    dir = 1'b0;
`endif
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'd0);

    // Reset held two cycles
    tick();
    tick();
    checkOutput("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    checkOutput("reset_release", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single-shot full mask, dwell 2
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hFF, 8'd2);
    tick();
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 2; k++) begin
        exp_sel = 3'(c);
        checkOutput($sformatf("ss_ch%0d_%0d", c, k), exp_sel, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
      end
    end
    checkOutput("ss_done", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("ss_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Continuous sparse mask 1010_0100, dwell 1
    seq3[0] = 3'd2; seq3[1] = 3'd5; seq3[2] = 3'd7;
    seq3[3] = 3'd2; seq3[4] = 3'd5; seq3[5] = 3'd7;
    seq3[6] = 3'd2; seq3[7] = 3'd5; seq3[8] = 3'd7;
    applyStimulus(1'b1, 1'b0, 1'b1, 8'b1010_0100, 8'd1);
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checkOutput($sformatf("cont_%0d", i), seq3[i], 1'b1, 1'b1,
                  (i > 0 && seq3[i] == 3'd2), 1'b0);
      if (i < 8) tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checkOutput("cont_stop", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Empty mask at start
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'd3);
    tick();
    start = 1'b0;
    checkOutput("err_pulse", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("err_clear", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stop while sel=3
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF, 8'd1);
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("pre_stop_sel3", 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checkOutput("stop_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // start and stop together in ACTIVE: stop wins
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF, 8'd4);
    tick();
    checkOutput("ss_restart", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    stop = 1'b1;
    tick();
    checkOutput("start_stop_both", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    stop  = 1'b0;
    tick();
    checkOutput("start_stop_after", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // dwell=0 acts as 1, mask 8'h81 single-shot
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h81, 8'd0);
    tick();
    start = 1'b0;
    checkOutput("d0_ch0", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("d0_ch7", 3'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("d0_done", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Mask, dwell and mode changes mid-sweep are ignored
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h0C, 8'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF, 8'd5);
    checkOutput("mchg_ch2", 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("mchg_ch3", 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("mchg_done", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-sweep
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF, 8'd3);
    tick();
    start = 1'b0;
    checkOutput("rst_mid_ch0", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("rst_mid_ch1", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    checkOutput("rst_mid", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    checkOutput("rst_mid_after", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
